// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the CPU/DMA main-memory arbiter.
// Round-robin winner selection lives here so the rule is stated once.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_DMA  = 2'b10;

  // On a tie the side that did not own the bus last time wins.
  function automatic logic pick_owner(input logic cpu_req_i,
                                      input logic dma_req_i,
                                      input logic last_owner_i);
    logic winner;
    if (cpu_req_i && dma_req_i) begin
      winner = ~last_owner_i;
    end else if (cpu_req_i) begin
      winner = OWN_CPU;
    end else begin
      winner = OWN_DMA;
    end
    return winner;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_cnt.sv
// Loadable 4-bit down-counter timing how long mem_en is held per access.
// zero is combinational so the FSM can leave ACCESS on the final cycle.
module mem_lat_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_r;

  // Count register: load has priority, decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing single-port main memory between the CPU
// controller and the DMA engine; all memory-side outputs are registered.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW      = 12,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] rdata,
  output logic          cpu_ack,
  output logic          dma_ack,
  output logic [1:0]    grant,
  output logic          wait_
);

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  arb_state_e    state_r, state_nx_s;
  logic [1:0]    grant_r, grant_nx_s;
  logic          mem_en_r, mem_en_nx_s;
  logic          mem_we_r, mem_we_nx_s;
  logic [AW-1:0] mem_addr_r, mem_addr_nx_s;
  logic [DW-1:0] mem_wdata_r, mem_wdata_nx_s;
  logic [DW-1:0] rdata_r, rdata_nx_s;
  logic          cpu_ack_r, cpu_ack_nx_s;
  logic          dma_ack_r, dma_ack_nx_s;
  logic          last_owner_r, last_owner_nx_s;
  logic          winner_s;
  logic          load_s;
  logic          dec_s;
  logic          cnt_zero_s;

  mem_lat_counter u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .load_val (LAT_LOAD),
    .dec      (dec_s),
    .zero     (cnt_zero_s)
  );

  // Next-state and next-output logic for the IDLE/ACCESS/ACK sequence.
  always_comb begin
    state_nx_s      = state_r;
    grant_nx_s      = grant_r;
    mem_en_nx_s     = mem_en_r;
    mem_we_nx_s     = mem_we_r;
    mem_addr_nx_s   = mem_addr_r;
    mem_wdata_nx_s  = mem_wdata_r;
    rdata_nx_s      = rdata_r;
    cpu_ack_nx_s    = 1'b0;
    dma_ack_nx_s    = 1'b0;
    last_owner_nx_s = last_owner_r;
    winner_s        = last_owner_r;
    load_s          = 1'b0;
    dec_s           = 1'b0;

    case (state_r)
      IDLE: begin
        if (cpu_req || dma_req) begin
          winner_s = pick_owner(cpu_req, dma_req, last_owner_r);
          if (winner_s == OWN_CPU) begin
            mem_we_nx_s    = cpu_we;
            mem_addr_nx_s  = cpu_addr;
            mem_wdata_nx_s = cpu_wdata;
            grant_nx_s     = GNT_CPU;
          end else begin
            mem_we_nx_s    = dma_we;
            mem_addr_nx_s  = dma_addr;
            mem_wdata_nx_s = dma_wdata;
            grant_nx_s     = GNT_DMA;
          end
          last_owner_nx_s = winner_s;
          load_s          = 1'b1;
          mem_en_nx_s     = 1'b1;
          state_nx_s      = ACCESS;
        end else begin
          state_nx_s = IDLE;
        end
      end

      ACCESS: begin
        if (cnt_zero_s) begin
          // Read data is only valid on the final enabled cycle.
          if (!mem_we_r) begin
            rdata_nx_s = mem_rdata;
          end else begin
            rdata_nx_s = rdata_r;
          end
          mem_en_nx_s  = 1'b0;
          mem_we_nx_s  = 1'b0;
          cpu_ack_nx_s = (grant_r == GNT_CPU);
          dma_ack_nx_s = (grant_r == GNT_DMA);
          state_nx_s   = ACK;
        end else begin
          dec_s      = 1'b1;
          state_nx_s = ACCESS;
        end
      end

      ACK: begin
        grant_nx_s = GNT_NONE;
        state_nx_s = IDLE;
      end

      default: begin
        grant_nx_s  = GNT_NONE;
        mem_en_nx_s = 1'b0;
        mem_we_nx_s = 1'b0;
        state_nx_s  = IDLE;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      grant_r      <= GNT_NONE;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      rdata_r      <= '0;
      cpu_ack_r    <= 1'b0;
      dma_ack_r    <= 1'b0;
      last_owner_r <= OWN_DMA;
    end else begin
      state_r      <= state_nx_s;
      grant_r      <= grant_nx_s;
      mem_en_r     <= mem_en_nx_s;
      mem_we_r     <= mem_we_nx_s;
      mem_addr_r   <= mem_addr_nx_s;
      mem_wdata_r  <= mem_wdata_nx_s;
      rdata_r      <= rdata_nx_s;
      cpu_ack_r    <= cpu_ack_nx_s;
      dma_ack_r    <= dma_ack_nx_s;
      last_owner_r <= last_owner_nx_s;
    end
  end

  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign rdata     = rdata_r;
  assign cpu_ack   = cpu_ack_r;
  assign dma_ack   = dma_ack_r;
  assign grant     = grant_r;
  assign wait_     = cpu_req & ~cpu_ack_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter with a transaction-level
// round-robin model and a separate reference memory.
module tb_mem_bus_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [11:0] cpu_addr, dma_addr, mem_addr;
  logic [15:0] cpu_wdata, dma_wdata, mem_rdata, mem_wdata, rdata;
  logic        mem_en, mem_we, cpu_ack, dma_ack, wait_;
  logic [1:0]  grant;

  int tests = 0;
  int fails = 0;

  bit [15:0] env_mem [0:4095];
  bit        env_vld [0:4095];
  bit [15:0] ref_mem [0:4095];
  bit        ref_vld [0:4095];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(12), .DW(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .mem_rdata(mem_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .rdata(rdata), .cpu_ack(cpu_ack), .dma_ack(dma_ack),
    .grant(grant), .wait_(wait_)
  );

  function automatic logic [15:0] init_val(input logic [11:0] a);
    if (a == 12'h010) return 16'hBEEF;
    return {4'hA, a} ^ 16'h0F0F;
  endfunction

  // Memory device: written by the DUT's write cycles, unwritten words read init_val.
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      env_mem[mem_addr] <= mem_wdata;
      env_vld[mem_addr] <= 1'b1;
    end
  end
  assign mem_rdata = env_vld[mem_addr] ? env_mem[mem_addr] : init_val(mem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h000; cpu_wdata = 16'h0000;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 12'h000; dma_wdata = 16'h0000;
    step;
    step;
    rst_n = 1'b1;
    step;
  endtask

  logic        pc, pd, cw, dw, win, lo, ew;
  logic [11:0] ca, da, ea;
  logic [15:0] cd, dd, ewd, exp_rd;

  initial begin
    // Reset values
    do_reset;
    rst_n = 1'b0;
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 12'h000);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_acks", {cpu_ack, dma_ack}, 2'b00);
    check("rst_wait", wait_, 1'b0);
    rst_n = 1'b1;
    step;

    // Single CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    #1; check("t1_wait_c0", wait_, 1'b1);
    step;
    check("t1_en_c1", mem_en, 1'b1);
    check("t1_grant_c1", grant, 2'b01);
    check("t1_addr_c1", mem_addr, 12'h010);
    check("t1_wait_c1", wait_, 1'b1);
    step;
    check("t1_en_c2", mem_en, 1'b1);
    check("t1_ack_c2", cpu_ack, 1'b0);
    step;
    check("t1_en_c3", mem_en, 1'b0);
    check("t1_ack_c3", cpu_ack, 1'b1);
    check("t1_rdata", rdata, 16'hBEEF);
    check("t1_wait_c3", wait_, 1'b0);
    cpu_req = 1'b0;
    step;
    check("t1_ack_c4", cpu_ack, 1'b0);
    check("t1_grant_c4", grant, 2'b00);

    // DMA write
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h3FF; dma_wdata = 16'h1234;
    for (int k = 1; k <= LAT; k++) begin
      step;
      check("t2_en", mem_en, 1'b1);
      check("t2_we", mem_we, 1'b1);
      check("t2_addr", mem_addr, 12'h3FF);
      check("t2_wdata", mem_wdata, 16'h1234);
      check("t2_grant", grant, 2'b10);
    end
    step;
    check("t2_acks", {cpu_ack, dma_ack}, 2'b01);
    check("t2_rdata_kept", rdata, 16'hBEEF);
    check("t2_en_off", mem_en, 1'b0);
    dma_req = 1'b0;
    step;
    check("t2_ack_once", dma_ack, 1'b0);

    // Contention from reset: CPU, DMA, CPU, DMA
    do_reset;
    cpu_req = 1'b1; cpu_addr = 12'h001;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'h002;
    for (int i = 0; i < 4; i++) begin
      step;
      check("t3_grant", grant, (i % 2 == 0) ? 2'b01 : 2'b10);
      step;
      step;
      check("t3_acks", {dma_ack, cpu_ack}, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i % 2 == 0) cpu_req = 1'b0; else dma_req = 1'b0;
      step;
      check("t3_idle_grant", grant, 2'b00);
      cpu_req = 1'b1; dma_req = 1'b1;
    end

    // CPU drops request mid-access
    do_reset;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h020;
    step;
    cpu_req = 1'b0; cpu_addr = 12'h777; cpu_we = 1'b1;
    step;
    check("t4_addr_held", mem_addr, 12'h020);
    check("t4_en", mem_en, 1'b1);
    step;
    check("t4_ack", cpu_ack, 1'b1);
    check("t4_rdata", rdata, 16'hAF2F);
    check("t4_wait", wait_, 1'b0);
    step;
    check("t4_idle", {grant, mem_en, cpu_ack}, 4'b0000);
    cpu_we = 1'b0;

    // DMA arrives in CPU ACK cycle
    cpu_req = 1'b1; cpu_addr = 12'h030;
    step; step; step;
    check("t5_cpu_ack", cpu_ack, 1'b1);
    cpu_req = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'h055;
    #1; check("t5_grant_ack", grant, 2'b01);
    step;
    check("t5_grant_idle", grant, 2'b00);
    check("t5_en_idle", mem_en, 1'b0);
    step;
    check("t5_grant_dma", grant, 2'b10);
    check("t5_addr_dma", mem_addr, 12'h055);
    step; step;
    check("t5_dma_ack", dma_ack, 1'b1);
    dma_req = 1'b0;
    step;

    // Reset in the middle of an access
    dma_req = 1'b1; dma_addr = 12'h066;
    step;
    check("t6_dma_grant", grant, 2'b10);
    cpu_req = 1'b1; cpu_addr = 12'h011;
    rst_n = 1'b0;
    #1;
    check("t6_abort", {grant, mem_en, cpu_ack, dma_ack}, 5'b00000);
    #3 rst_n = 1'b1;
    step;
    check("t6_tie_cpu", grant, 2'b01);
    step; step;
    check("t6_ack", {dma_ack, cpu_ack}, 2'b01);

    // Randomized traffic against the round-robin model
    do_reset;
    pc = 1'b0; pd = 1'b0; lo = 1'b1; exp_rd = 16'h0000;
    cw = 1'b0; dw = 1'b0; ca = 12'h000; da = 12'h000; cd = 16'h0000; dd = 16'h0000;
    for (int it = 0; it < 80; it++) begin
      if (!pc && ($urandom_range(0, 2) != 0)) begin
        pc = 1'b1; cw = 1'($urandom); ca = 12'h100 + 12'($urandom_range(0, 15)); cd = 16'($urandom);
      end
      if (!pd && ($urandom_range(0, 2) != 0)) begin
        pd = 1'b1; dw = 1'($urandom); da = 12'h100 + 12'($urandom_range(0, 15)); dd = 16'($urandom);
      end
      cpu_req = pc; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dma_req = pd; dma_we = dw; dma_addr = da; dma_wdata = dd;
      #1; check("rnd_wait_idle", wait_, pc);
      if (!pc && !pd) begin
        step;
        check("rnd_no_grant", grant, 2'b00);
      end else begin
        if (pc && pd) win = ~lo; else win = pd && !pc;
        lo = win;
        ew  = win ? dw : cw;
        ea  = win ? da : ca;
        ewd = win ? dd : cd;
        for (int k = 1; k <= LAT; k++) begin
          step;
          check("rnd_grant", grant, win ? 2'b10 : 2'b01);
          check("rnd_en", mem_en, 1'b1);
          check("rnd_we", mem_we, ew);
          check("rnd_addr", mem_addr, ea);
          if (ew) check("rnd_wdata", mem_wdata, ewd);
          if (k == 1 && !pc && $urandom_range(0, 1) == 1) begin
            pc = 1'b1; cw = 1'($urandom); ca = 12'h100 + 12'($urandom_range(0, 15)); cd = 16'($urandom);
            cpu_req = 1'b1; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
          end
          if (k == 1 && !pd && $urandom_range(0, 1) == 1) begin
            pd = 1'b1; dw = 1'($urandom); da = 12'h100 + 12'($urandom_range(0, 15)); dd = 16'($urandom);
            dma_req = 1'b1; dma_we = dw; dma_addr = da; dma_wdata = dd;
          end
        end
        step;
        if (ew) begin
          ref_mem[ea] = ewd; ref_vld[ea] = 1'b1;
        end else begin
          exp_rd = ref_vld[ea] ? ref_mem[ea] : init_val(ea);
        end
        check("rnd_acks", {dma_ack, cpu_ack}, win ? 2'b10 : 2'b01);
        check("rnd_rdata", rdata, exp_rd);
        check("rnd_en_off", mem_en, 1'b0);
        if (win) pd = 1'b0; else pc = 1'b0;
        cpu_req = pc; dma_req = pd;
        #1; check("rnd_wait_ack", wait_, pc && win);
        step;
        check("rnd_idle", {grant, cpu_ack, dma_ack}, 4'b0000);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port main memory between the microprogrammed CPU controller and a DMA engine.
- Round-robin arbitration. Each granted access holds the memory bus for MEM_LAT cycles, then returns read data with a one-cycle ack.
- Drives the CPU controller's wait_ input, so microcode branches on wait_ until the CPU's memory access completes.

Parameters:
- AW, 12, memory address width.
- DW, 16, memory data width.
- MEM_LAT, 2, cycles mem_en is held per access (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cpu_req  input  1  CPU access request; held until cpu_ack.
- cpu_we  input  1  CPU write (1) / read (0).
- cpu_addr  input  AW  CPU address.
- cpu_wdata  input  DW  CPU write data.
- dma_req  input  1  DMA access request; held until dma_ack.
- dma_we  input  1  DMA write / read.
- dma_addr  input  AW  DMA address.
- dma_wdata  input  DW  DMA write data.
- mem_rdata  input  DW  memory read data, valid on the last mem_en cycle.
- mem_en  output  1  memory enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- rdata  output  DW  read data returned to the acked requester.
- cpu_ack  output  1  one-cycle completion pulse to the CPU.
- dma_ack  output  1  one-cycle completion pulse to the DMA.
- grant  output  2  one-hot owner of the bus: [0]=CPU, [1]=DMA, 00=idle.
- wait_  output  1  to the CPU controller: 1 while cpu_req=1 and cpu_ack=0, else 0. Combinational.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, grant=00, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rdata=0, cpu_ack=0, dma_ack=0, latency counter=0.
  - last_owner=DMA, so the CPU wins the first tie.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No request → stay in IDLE.
  - Single request → that requester is granted.
  - Both requesting → grant goes to the requester that is not last_owner.
  - On grant: latch we/addr/wdata of the winner into mem_* registers, set grant, set last_owner=winner, load counter=MEM_LAT-1, go to ACCESS.
- ACCESS:
  - mem_en=1, mem_* stable.
  - Counter decrements each cycle.
  - When counter==0: if read, capture mem_rdata into rdata (writes leave rdata unchanged); go to ACK. mem_en drops on entry to ACK.
- ACK:
  - Acks are registered. The owner's ack is high for exactly this one cycle.
  - grant is held through ACK and cleared on return to IDLE. The requester drops req during the ACK cycle.
  - IDLE re-arbitrates on the next edge.
- Latency: req asserted in IDLE at cycle 0 → mem_en high in cycles 1..MEM_LAT → ack in cycle MEM_LAT+1 → next grant no earlier than cycle MEM_LAT+3.
- Requests that change or drop during ACCESS are ignored. The latched access completes and ack is still pulsed.
- A request arriving during ACCESS or ACK waits; it is arbitrated only in IDLE.
- Under continuous contention, grants alternate CPU, DMA, CPU, …. Neither side starves.
- Reset asserted mid-access aborts immediately to reset values; no ack is issued.
- wait_ rises combinationally with cpu_req, including the grant and ACCESS cycles, and falls in the cpu_ack cycle.

Decomposition:
- Shared package contents:
  - state encodings IDLE=2'd0, ACCESS=2'd1, ACK=2'd2;
  - owner constants OWN_CPU=1'b0, OWN_DMA=1'b1;
  - grant codes GNT_NONE=2'b00, GNT_CPU=2'b01, GNT_DMA=2'b10.
- One sub-module, mem_lat_counter:
  - loadable 4-bit down-counter with async active-low reset;
  - ports clk, rst_n, load, load_val, dec, zero.

Test Plan:
- Reset then single CPU read, addr=12'h010, mem_rdata=16'hBEEF, MEM_LAT=2 → mem_en high in cycles 1-2, cpu_ack in cycle 3, rdata=16'hBEEF, wait_ 1 in cycles 0-2 and 0 in cycle 3.
- DMA write, addr=12'h3FF, wdata=16'h1234 → mem_we=1, mem_addr=12'h3FF, mem_wdata=16'h1234 for 2 cycles; dma_ack pulses once; rdata unchanged; grant=10.
- CPU and DMA request together from reset → CPU served first (grant=01); DMA granted after CPU ack; with both held continuously, a 4-grant sequence is CPU, DMA, CPU, DMA.
- CPU drops cpu_req during ACCESS → access completes, cpu_ack still pulses, FSM returns to IDLE.
- DMA request arrives in the CPU's ACK cycle → no grant change until IDLE; DMA granted the cycle after IDLE.
- rst_n pulsed low in the middle of ACCESS → mem_en, grant and acks are 0 immediately; FSM is IDLE; the next tie is won by the CPU.
